// File: rtl/canny_frame_ctrl.sv
// Frame/line sequencer for a Canny edge pipeline: vsync start-up, line gaps,
// pixel-pair streaming with downstream backpressure and 3x3 window flags.
module canny_frame_ctrl #(
  parameter int WIDTH          = 768,
  parameter int HEIGHT         = 512,
  parameter int START_UP_DELAY = 100,
  parameter int HSYNC_DELAY    = 160
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       start,
  input  logic       abort,
  input  logic       ds_ready,
  output logic       VSYNC,
  output logic       HSYNC,
  output logic [9:0] ROW,
  output logic [9:0] COL,
  output logic       WIN_VALID,
  output logic       BORDER,
  output logic       BUSY,
  output logic       FRAME_DONE
);

  localparam logic [9:0]  LAST_COL = 10'(WIDTH - 2);
  localparam logic [9:0]  LAST_ROW = 10'(HEIGHT - 1);
  localparam logic [15:0] VS_LAST  = 16'(START_UP_DELAY - 1);
  localparam logic [15:0] HG_LAST  = 16'(HSYNC_DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_HGAP,
    S_DATA,
    S_DONE
  } state_t;

  state_t      st_q, st_d;
  logic [15:0] cnt_q, cnt_d;
  logic [9:0]  row_q, row_d;
  logic [9:0]  col_q, col_d;
  logic        vs_q, vs_d;
  logic        hs_q, hs_d;
  logic        win_q, win_d;
  logic        bord_q, bord_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    row_d  = row_q;
    col_d  = col_q;
    vs_d   = 1'b0;
    hs_d   = 1'b0;
    done_d = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        cnt_d = '0;
        row_d = '0;
        col_d = '0;
        if (start) begin
          st_d = S_VSYNC;
          vs_d = 1'b1;
        end
      end
      S_VSYNC: begin
        if (cnt_q == VS_LAST) begin
          st_d  = S_HGAP;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
          vs_d  = 1'b1;
        end
      end
      S_HGAP: begin
        if (cnt_q == HG_LAST) begin
          st_d  = S_DATA;
          cnt_d = '0;
          hs_d  = ds_ready;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        // HSYNC is ds_ready registered; the pair shown is consumed when it
        // was flagged valid, so each COL gets exactly one valid cycle.
        hs_d = ds_ready;
        if (hs_q) begin
          if (col_q == LAST_COL) begin
            hs_d = 1'b0;
            if (row_q == LAST_ROW) begin
              st_d   = S_DONE;
              done_d = 1'b1;
            end else begin
              st_d  = S_HGAP;
              row_d = row_q + 10'd1;
              col_d = '0;
            end
          end else begin
            col_d = col_q + 10'd2;
          end
        end
      end
      S_DONE: begin
        st_d  = S_IDLE;
        row_d = '0;
        col_d = '0;
      end
      default: st_d = S_IDLE;
    endcase
    if (abort && st_q != S_IDLE) begin
      st_d   = S_IDLE;
      cnt_d  = '0;
      row_d  = '0;
      col_d  = '0;
      vs_d   = 1'b0;
      hs_d   = 1'b0;
      done_d = 1'b0;
    end
    busy_d = (st_d != S_IDLE);
    win_d  = hs_d && (row_d >= 10'd2);
    bord_d = hs_d && (row_d == '0 || row_d == LAST_ROW ||
                      col_d == '0 || col_d == LAST_COL);
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      st_q   <= S_IDLE;
      cnt_q  <= '0;
      row_q  <= '0;
      col_q  <= '0;
      vs_q   <= 1'b0;
      hs_q   <= 1'b0;
      win_q  <= 1'b0;
      bord_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      row_q  <= row_d;
      col_q  <= col_d;
      vs_q   <= vs_d;
      hs_q   <= hs_d;
      win_q  <= win_d;
      bord_q <= bord_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign VSYNC      = vs_q;
  assign HSYNC      = hs_q;
  assign ROW        = row_q;
  assign COL        = col_q;
  assign WIN_VALID  = win_q;
  assign BORDER     = bord_q;
  assign BUSY       = busy_q;
  assign FRAME_DONE = done_q;

endmodule

// File: tb/tb_canny_frame_ctrl.sv
// Bench for canny_frame_ctrl: per-cycle trace compare against a frame model
// built from a per-cycle ds_ready schedule.
module tb_canny_frame_ctrl;

  localparam int W = 8;
  localparam int H = 4;
  localparam int S = 3;
  localparam int G = 2;
  localparam int N = 600;

  logic       HCLK = 1'b0;
  logic       HRESET, start, abort, ds_ready;
  logic       VSYNC, HSYNC, WIN_VALID, BORDER, BUSY, FRAME_DONE;
  logic [9:0] ROW, COL;

  canny_frame_ctrl #(
    .WIDTH(W), .HEIGHT(H), .START_UP_DELAY(S), .HSYNC_DELAY(G)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .abort(abort),
    .ds_ready(ds_ready), .VSYNC(VSYNC), .HSYNC(HSYNC), .ROW(ROW),
    .COL(COL), .WIN_VALID(WIN_VALID), .BORDER(BORDER), .BUSY(BUSY),
    .FRAME_DONE(FRAME_DONE)
  );

  always #5 HCLK = ~HCLK;

  int          n_chk = 0;
  int          n_fail = 0;
  bit          rdy [N];
  logic [25:0] exp_o [N];
  int          exp_len, exp_done;
  int          hs_cnt, win_cnt, bord_low, done_seen;

  function automatic logic [25:0] mk(bit v, bit h, bit busy, bit d,
                                      int r, int c);
    bit win, bd;
    win = h && (r >= 2);
    bd  = h && (r == 0 || r == H - 1 || c == 0 || c == W - 2);
    return {v, h, win, bd, busy, d, 10'(r), 10'(c)};
  endfunction

  function automatic logic [25:0] act();
    return {VSYNC, HSYNC, WIN_VALID, BORDER, BUSY, FRAME_DONE, ROW, COL};
  endfunction

  // Cycle t is the interval after edge t-1; ds_ready for edge t is rdy[t].
  task automatic build_model();
    int t;
    bit h;
    t = 1;
    for (int i = 0; i < S; i++) begin
      exp_o[t] = mk(1, 0, 1, 0, 0, 0);
      t++;
    end
    for (int r = 0; r < H; r++) begin
      for (int g = 0; g < G; g++) begin
        exp_o[t] = mk(0, 0, 1, 0, r, 0);
        t++;
      end
      for (int c = 0; c < W; c += 2) begin
        do begin
          h = rdy[t - 1];
          exp_o[t] = mk(0, h, 1, 0, r, c);
          t++;
        end while (!h);
      end
    end
    exp_o[t] = mk(0, 0, 1, 1, H - 1, W - 2);
    exp_done = t;
    t++;
    exp_o[t] = '0;
    exp_len = t;
  endtask

  task automatic fill_rdy(input int mode);
    for (int t = 0; t < N; t++)
      rdy[t] = (mode == 0 || t >= 200) ? 1'b1 : ($urandom_range(0, 3) != 0);
  endtask

  task automatic run_frame(input string name, input int abort_at,
                           input bit poke_start);
    int last;
    logic [25:0] e;
    hs_cnt = 0; win_cnt = 0; bord_low = 0; done_seen = 0;
    build_model();
    start = 1; abort = 0; ds_ready = rdy[0];
    @(posedge HCLK); #1;
    start = 0;
    last = (abort_at > 0) ? abort_at + 1 : exp_len;
    for (int t = 1; t <= last; t++) begin
      e = (abort_at > 0 && t == abort_at + 1) ? 26'd0 : exp_o[t];
      n_chk++;
      if (act() !== e) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, t, act(), e);
      end
      if (HSYNC === 1'b1 && (abort_at == 0 || t < abort_at)) hs_cnt++;
      if (WIN_VALID === 1'b1) win_cnt++;
      if (HSYNC === 1'b1 && BORDER === 1'b0) bord_low++;
      if (FRAME_DONE === 1'b1) done_seen = t;
      ds_ready = rdy[t];
      abort = (t == abort_at);
      start = poke_start && (t == exp_done - 2 || t == exp_done);
      @(posedge HCLK); #1;
    end
    start = 0; abort = 0; ds_ready = 1;
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    HRESET = 1; start = 0; abort = 0; ds_ready = 1;
    #3;
    n_chk++;
    if (act() !== 26'd0) begin
      n_fail++;
      $display("FAIL reset: got %h expected 0", act());
    end
    @(posedge HCLK); @(posedge HCLK); #1;
    HRESET = 0;
    @(posedge HCLK); #1;
    n_chk++;
    if (act() !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_idle: got %h expected 0", act());
    end
  endtask

  task automatic test_nominal();
    fill_rdy(0);
    run_frame("nominal", 0, 0);
    chk_int("nominal_hsync", hs_cnt, W / 2 * H);
    chk_int("nominal_done_cycle", done_seen, 28);
    chk_int("nominal_win", win_cnt, 8);
    chk_int("nominal_border_low", bord_low, 4);
  endtask

  task automatic test_backpressure();
    fill_rdy(0);
    for (int t = 13; t <= 15; t++) rdy[t] = 1'b0;
    run_frame("backpressure", 0, 0);
    chk_int("bp_hsync", hs_cnt, W / 2 * H);
    chk_int("bp_done_cycle", done_seen, 31);
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      fill_rdy(1);
      run_frame("random", 0, 0);
      chk_int("random_hsync", hs_cnt, W / 2 * H);
      chk_int("random_win", win_cnt, 8);
    end
  endtask

  task automatic test_abort();
    fill_rdy(0);
    run_frame("abort_last", 27, 0);
    chk_int("abort_last_hsync", hs_cnt, 15);
    chk_int("abort_last_done", done_seen, 0);
    run_frame("abort_vsync", 2, 0);
    run_frame("abort_hgap", 5, 0);
    fill_rdy(1);
    run_frame("abort_rand", 20 + $urandom_range(0, 6), 0);
  endtask

  task automatic test_start_ignored();
    fill_rdy(0);
    run_frame("start_ignored", 0, 1);
    chk_int("start_ign_hsync", hs_cnt, W / 2 * H);
    for (int i = 0; i < 4; i++) begin
      chk_int("start_not_queued_busy", int'(BUSY), 0);
      @(posedge HCLK); #1;
    end
  endtask

  task automatic test_reset_mid();
    int n;
    fill_rdy(0);
    start = 1;
    @(posedge HCLK); #1;
    start = 0;
    n = 0;
    while (ROW !== 10'd2 && n < 60) begin
      @(posedge HCLK); #1;
      n++;
    end
    chk_int("reach_row2_budget", int'(n < 60), 1);
    #2 HRESET = 1;
    #1;
    n_chk++;
    if (act() !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %h expected 0", act());
    end
    @(posedge HCLK); #1;
    HRESET = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge HCLK); #1;
      n_chk++;
      if (act() !== 26'd0) begin
        n_fail++;
        $display("FAIL reset_mid_idle: got %h expected 0", act());
      end
    end
    run_frame("after_reset", 0, 0);
    chk_int("after_reset_hsync", hs_cnt, W / 2 * H);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_random();
    test_abort();
    test_start_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
